// File: rtl/rect_fill_engine_if.sv
// ============================================================================
// Module   : rect_fill_engine_if
// Purpose  : Fill-request handshake plus the x/y/colour/plot pixel write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rect_fill_engine_if;
   logic       start;
   logic [7:0] x0;
   logic [6:0] y0;
   logic [7:0] width;
   logic [6:0] height;
   logic [2:0] colour_in;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   modport master (
      output start, x0, y0, width, height, colour_in,
      input  x, y, colour, plot, busy, done
   );

   modport slave (
      input  start, x0, y0, width, height, colour_in,
      output x, y, colour, plot, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/rect_fill_engine.sv
// ============================================================================
// Module   : rect_fill_engine
// Purpose  : Streams one clipped rectangle fill, pixel per clock, to vga_adapter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rect_fill_engine #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  wire logic         clock,
   input  wire logic         reset,
   rect_fill_engine_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_DRAW  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [8:0] c_w    = 9'(SCREEN_W);
   localparam logic [8:0] c_h    = 9'(SCREEN_H);
   localparam logic [8:0] c_xmax = 9'(SCREEN_W - 1);
   localparam logic [8:0] c_ymax = 9'(SCREEN_H - 1);

   state_t     r_state;
   logic [7:0] r_x0;
   logic [6:0] r_y0;
   logic [7:0] r_width;
   logic [6:0] r_height;
   logic [2:0] r_colour_l;
   logic [8:0] r_xe;
   logic [8:0] r_ye;
   logic [7:0] r_x;
   logic [6:0] r_y;
   logic [2:0] r_colour;
   logic       r_plot;
   logic       r_busy;
   logic       r_done;

   logic [8:0] w_x_end_raw;
   logic [8:0] w_y_end_raw;
   logic [8:0] w_xe;
   logic [8:0] w_ye;
   logic       w_empty;
   logic       w_x_last;
   logic       w_y_last;

   // 9-bit sums so x0+width-1 cannot wrap before clipping to the screen edge
   assign w_x_end_raw = {1'b0, r_x0} + {1'b0, r_width} - 9'd1;
   assign w_y_end_raw = {2'b00, r_y0} + {2'b00, r_height} - 9'd1;
   assign w_xe        = (w_x_end_raw > c_xmax) ? c_xmax : w_x_end_raw;
   assign w_ye        = (w_y_end_raw > c_ymax) ? c_ymax : w_y_end_raw;
   assign w_empty     = (r_width == 8'd0) || (r_height == 7'd0) ||
                        ({1'b0, r_x0} >= c_w) || ({2'b00, r_y0} >= c_h);
   assign w_x_last    = ({1'b0, r_x} == r_xe);
   assign w_y_last    = ({2'b00, r_y} == r_ye);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_x0       <= '0;
         r_y0       <= '0;
         r_width    <= '0;
         r_height   <= '0;
         r_colour_l <= '0;
         r_xe       <= '0;
         r_ye       <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_colour   <= '0;
         r_plot     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_x0       <= bus.x0;
                  r_y0       <= bus.y0;
                  r_width    <= bus.width;
                  r_height   <= bus.height;
                  r_colour_l <= bus.colour_in;
                  r_busy     <= 1'b1;
                  r_state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_xe <= w_xe;
               r_ye <= w_ye;
               if (w_empty) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_x      <= r_x0;
                  r_y      <= r_y0;
                  r_colour <= r_colour_l;
                  r_plot   <= 1'b1;
                  r_state  <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (w_x_last && w_y_last) begin
                  // Coordinates stay on the final pixel so nothing off-rectangle is ever driven
                  r_plot  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (w_x_last) begin
                  r_x <= r_x0;
                  r_y <= r_y + 7'd1;
               end else begin
                  r_x <= r_x + 8'd1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_plot  <= 1'b0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.x      = r_x;
   assign bus.y      = r_y;
   assign bus.colour = r_colour;
   assign bus.plot   = r_plot;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
// ============================================================================
// Module   : tb_rect_fill_engine
// Purpose  : Directed fills with hand-computed extents, order and coverage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rect_fill_engine;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   cnt [160][120];

   rect_fill_engine_if bus ();

   rect_fill_engine #(
      .SCREEN_W (160),
      .SCREEN_H (120)
   ) u_dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive_req(input int x0_v, input int y0_v, input int w_v,
                            input int h_v, input int col_v);
      bus.start     = 1'b1;
      bus.x0        = 8'(x0_v);
      bus.y0        = 7'(y0_v);
      bus.width     = 8'(w_v);
      bus.height    = 7'(h_v);
      bus.colour_in = 3'(col_v);
   endtask

   // Expected extents and pixel count are supplied by hand per vector
   task automatic run_fill(input string tag, input int x0_v, input int y0_v,
                           input int w_v, input int h_v, input int col_v,
                           input int exp_xe, input int exp_ye, input int exp_n,
                           input int inj_cycle);
      int plots, done_cyc, first_cyc, last_cyc;
      int ord_err, col_err, rng_err, cov_err, ex, ey, expc;
      plots = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
      ord_err = 0; col_err = 0; rng_err = 0; cov_err = 0;
      ex = x0_v; ey = y0_v;
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++)
            cnt[i][j] = 0;

      @(negedge clk);
      drive_req(x0_v, y0_v, w_v, h_v, col_v);
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_setup_busy"}, int'(bus.busy), 1);
      check({tag, "_setup_plot"}, int'(bus.plot), 0);

      for (int k = 2; k < exp_n + 10 && done_cyc < 0; k++) begin
         @(negedge clk);
         if (bus.plot) begin
            plots++;
            if (first_cyc < 0) first_cyc = k;
            last_cyc = k;
            if (bus.x >= 8'd160 || bus.y >= 7'd120) rng_err++;
            else cnt[bus.x][bus.y]++;
            if (int'(bus.x) != ex || int'(bus.y) != ey) ord_err++;
            if (int'(bus.colour) != col_v) col_err++;
            if (ex == exp_xe) begin
               ex = x0_v;
               ey++;
            end else begin
               ex++;
            end
         end
         if (bus.done) done_cyc = k;
         if (k == inj_cycle) drive_req(3, 3, 2, 2, 1);
         else if (k == inj_cycle + 1) bus.start = 1'b0;
      end

      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++) begin
            expc = (exp_n > 0 && i >= x0_v && i <= exp_xe &&
                    j >= y0_v && j <= exp_ye) ? 1 : 0;
            if (cnt[i][j] != expc) cov_err++;
         end

      check({tag, "_done_cycle"}, done_cyc, exp_n + 2);
      check({tag, "_plots"}, plots, exp_n);
      check({tag, "_order"}, ord_err, 0);
      check({tag, "_colour"}, col_err, 0);
      check({tag, "_range"}, rng_err, 0);
      check({tag, "_coverage"}, cov_err, 0);
      if (exp_n > 0) begin
         check({tag, "_first_cyc"}, first_cyc, 2);
         check({tag, "_last_cyc"}, last_cyc, exp_n + 1);
      end
      @(negedge clk);
      check({tag, "_idle_busy"}, int'(bus.busy), 0);
      check({tag, "_idle_done"}, int'(bus.done), 0);
      @(negedge clk);
      check({tag, "_no_queue"}, int'(bus.busy), 0);
   endtask

   initial begin
      int stray;
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.x0 = '0; bus.y0 = '0; bus.width = '0; bus.height = '0; bus.colour_in = '0;
      repeat (3) @(negedge clk);
      check("rst_x", int'(bus.x), 0);
      check("rst_y", int'(bus.y), 0);
      check("rst_colour", int'(bus.colour), 0);
      check("rst_plot", int'(bus.plot), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      rst = 1'b0;

      run_fill("fill2x2", 10, 20, 2, 2, 5, 11, 21, 4, -1);
      run_fill("clip", 158, 118, 5, 5, 3, 159, 119, 4, -1);
      run_fill("empty_w0", 5, 5, 0, 3, 1, 0, 0, 0, -1);
      run_fill("empty_x160", 160, 5, 4, 4, 1, 0, 0, 0, -1);
      run_fill("empty_y120", 5, 120, 4, 4, 1, 0, 0, 0, -1);
      run_fill("fill3x2", 100, 60, 3, 2, 2, 102, 61, 6, -1);
      run_fill("clip_tall", 0, 100, 1, 127, 4, 0, 119, 20, -1);
      run_fill("full", 0, 0, 160, 120, 7, 159, 119, 19200, -1);
      run_fill("busy_start", 10, 20, 2, 2, 5, 11, 21, 4, 3);

      // Reset in cycle 4 of a 3x3 fill at (20,30): third pixel (22,30) is on the port
      @(negedge clk);
      drive_req(20, 30, 3, 3, 6);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("rstmid_pre_plot", int'(bus.plot), 1);
      check("rstmid_pre_x", int'(bus.x), 22);
      rst = 1'b1;
      #1;
      check("rstmid_plot", int'(bus.plot), 0);
      check("rstmid_busy", int'(bus.busy), 0);
      check("rstmid_done", int'(bus.done), 0);
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done || bus.plot || bus.busy) stray++;
      end
      check("rstmid_quiet", stray, 0);
      run_fill("after_rst", 40, 50, 1, 1, 2, 40, 50, 1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
